serial_add_sub: RTL
===================

# serial_add_sub

Parametrised multi-cycle signed adder/subtractor that computes A + B or A − B, sign-extended to WIDTH+1 bits, processing DIGIT bits per clock through one shared DIGIT-bit ripple slice. It generalises the lab's combinational 8-bit ADD_SUB into a width/throughput-configurable datapath element with a start/done handshake and status flags. Multiplier and ALU control units use it when the area of a full-width ripple adder is not affordable.

## Interface
- WIDTH, default 8: operand width in bits. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, default 4: bits processed per cycle. Must be ≥ 1. N = WIDTH/DIGIT is the number of compute cycles.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- Fn  input  1  operation: 0 = A + B, 1 = A − B. Captured with Start.
- A  input  WIDTH  signed operand, captured with Start.
- B  input  WIDTH  signed operand, captured with Start.
- S  output  WIDTH+1  registered signed result.
- Busy  output  1  high while digits are being computed.
- Done  output  1  one-cycle pulse when S is valid.
- CarryOut  output  1  raw carry out of bit WIDTH−1. For subtract, 1 means no borrow.
- Overflow  output  1  signed overflow of the WIDTH-bit result: carry into bit WIDTH−1 XOR carry out of it.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + Start=1 → RUN:
  - latch A and BB = B ^ {WIDTH{Fn}};
  - load carry register with Fn;
  - clear digit counter.
- IDLE/DONE + Start=0: DONE → IDLE; IDLE holds.
- RUN, each cycle, for digit i = counter:
  - add A[i*DIGIT +: DIGIT] + BB[i*DIGIT +: DIGIT] + carry;
  - write the DIGIT sum bits into S[i*DIGIT +: DIGIT];
  - register the carry out;
  - increment the counter.
- RUN, last digit (i = N−1):
  - S[WIDTH] = A[WIDTH−1] ^ BB[WIDTH−1] ^ final carry (sign extension);
  - CarryOut = final carry;
  - Overflow = carry into bit WIDTH−1 XOR final carry;
  - go to DONE.
- The result is exact: S always equals the true WIDTH+1-bit signed sum or difference, with no wrap.
- Start while Busy=1 is ignored. Latched operands are not disturbed, and input changes during RUN have no effect.
- S, CarryOut and Overflow hold their last values from DONE until the next RUN writes them. Partial S bits may change during RUN; S is valid only when Done=1 or afterwards while idle.
- DIGIT = WIDTH (N=1) is legal: single-cycle RUN.

## Timing
- Reset values:
  - state IDLE, counter 0, carry 0;
  - S = 0, Busy = 0, Done = 0, CarryOut = 0, Overflow = 0.
- Reset has priority over Start in the same cycle.
- Start sampled high at edge k:
  - Busy = 1 after edges k … k+N−1 (exactly N cycles);
  - Done = 1 and final S/flags valid after edge k+N, for one cycle;
  - Busy = 0 in that cycle.
- Latency from Start to Done is N+1 edges. Throughput is one operation per N+1 cycles.
- Start asserted in the Done cycle is accepted: Busy rises at the next edge, with no idle gap.
- Reset asserted mid-RUN aborts at the next edge. All outputs return to reset values and no Done is produced for the aborted operation.
- All outputs are registered; no combinational input→output paths.

## Test plan
- **Add, overflow** (WIDTH=8, DIGIT=4): A=0x7F, B=0x01, Fn=0, Start.
  - Busy for 2 cycles, Done on the 3rd edge.
  - S=0x080, CarryOut=0, Overflow=1.
- **Subtract, overflow** (WIDTH=8, DIGIT=4): A=0x80, B=0x01, Fn=1.
  - S=0x17F (−129), CarryOut=1, Overflow=0→ no: Overflow=1.
- **Negative add** (WIDTH=8, DIGIT=4): A=0xFF, B=0xFF, Fn=0.
  - S=0x1FE (−2), CarryOut=1, Overflow=0.
- **Start while busy** (WIDTH=8, DIGIT=4): pulse Start with A=0x10, B=0x05, Fn=1.
  - Next cycle, change A/B to 0x00 and reassert Start.
  - Exactly one Done, S=0x00B; the second Start is ignored.
- **Back-to-back, serial** (WIDTH=16, DIGIT=1): Start every Done cycle with 0x1234+0x4321, then 0x0000−0x0001.
  - Results S=0x05555, then S=0x1FFFF.
  - Done pulses 17 cycles apart; Busy high 16 cycles each.
- **Reset mid-operation** (WIDTH=8, DIGIT=2): assert Reset after the 2nd RUN cycle.
  - Next edge: S=0, Busy=0, Done never pulses.
  - A subsequent Start of 0x03+0x04 gives S=0x007 after 5 edges.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for serial_add_sub.
// The master issues start/fn/a/b; the slave returns the registered result and status.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic                    fn;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic signed [WIDTH:0]   s;
  logic                    busy;
  logic                    done;
  logic                    carry_out;
  logic                    overflow;

  modport master (
    output start, fn, a, b,
    input  s, busy, done, carry_out, overflow
  );

  modport slave (
    input  start, fn, a, b,
    output s, busy, done, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial signed adder/subtractor: one DIGIT-bit ripple slice reused over
// WIDTH/DIGIT cycles, producing an exact WIDTH+1-bit sum or difference.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  serial_add_sub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    carry;
  logic signed [WIDTH-1:0] a_r;
  logic signed [WIDTH-1:0] bb_r;
  logic signed [WIDTH:0]   s_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    cout_r;
  logic                    ovf_r;

  logic [DIGIT-1:0]        a_dig;
  logic [DIGIT-1:0]        b_dig;
  logic [DIGIT:0]          sum;
  logic                    is_last;
  logic                    c_msb_in;
  logic signed [WIDTH:0]   s_nxt;
  logic                    accept;

  // One ripple slice: DIGIT sum bits plus carry out in the MSB.
  function automatic logic [DIGIT:0] digit_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  assign is_last = (cnt == LAST);
  assign accept  = (state != RUN) && bus.start;

  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int d = 0; d < N; d++) begin
      if (cnt == CW'(d)) begin
        a_dig = a_r[d*DIGIT +: DIGIT];
        b_dig = bb_r[d*DIGIT +: DIGIT];
      end
    end
  end

  assign sum = digit_add(a_dig, b_dig, carry);

  // On the last digit, slice bit DIGIT-1 is operand bit WIDTH-1; recover its carry-in.
  assign c_msb_in = a_r[WIDTH-1] ^ bb_r[WIDTH-1] ^ sum[DIGIT-1];

  always_comb begin
    s_nxt = s_r;
    for (int d = 0; d < N; d++) begin
      if (cnt == CW'(d)) s_nxt[d*DIGIT +: DIGIT] = sum[DIGIT-1:0];
    end
    if (is_last) s_nxt[WIDTH] = a_r[WIDTH-1] ^ bb_r[WIDTH-1] ^ sum[DIGIT];
  end

  // Operands are pure data: captured on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      a_r  <= bus.a;
      bb_r <= bus.b ^ {WIDTH{bus.fn}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      s_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            cnt    <= '0;
            carry  <= bus.fn;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          s_r   <= s_nxt;
          carry <= sum[DIGIT];
          if (is_last) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            cout_r <= sum[DIGIT];
            ovf_r  <= c_msb_in ^ sum[DIGIT];
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s         = s_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.carry_out = cout_r;
  assign bus.overflow  = ovf_r;

endmodule
